bram_access_controller: RTL
===========================

# bram_access_controller

Request-side front end for the single-port-pair BRAM used as instruction/data memory in the out-of-order core. It accepts word-addressed load/store requests over a valid/ready handshake, drives the BRAM read and write ports, and returns read data in order through a buffered response channel with backpressure. Sub-word stores are handled by read-modify-write, because the BRAM only writes whole words.

## Interface
- DATA_WIDTH, 32: word width. Must be a multiple of 8.
- ADDR_WIDTH, 8: word-address width.
- RSP_DEPTH, 4: response FIFO depth. Power of two, ≥2. A value ≥3 is required for one read per cycle.

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when both req_valid and req_ready are high
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  word address
- req_byte_en  in  DATA_WIDTH/8  store byte enables; ignored for loads
- req_wdata  in  DATA_WIDTH  store data
- rsp_valid  out  1  load data available
- rsp_ready  in  1  consumer takes the response
- rsp_rdata  out  DATA_WIDTH  load data; 0 when rsp_valid=0
- bram_read_enable  out  1
- bram_read_address  out  ADDR_WIDTH
- bram_read_data  in  DATA_WIDTH  registered BRAM output, valid one cycle after read enable
- bram_write_enable  out  1
- bram_write_address  out  ADDR_WIDTH
- bram_write_data  out  DATA_WIDTH

## Operation
- State machine: ACCEPT, RMW_WRITE.
- ACCEPT, req_ready = (fifo_count + inflight_load) < RSP_DEPTH. req_ready never depends on rsp_ready.
- Load accepted: drive bram_read_enable=1 and bram_read_address=req_addr in the same cycle, then set inflight_load. On the next cycle, push bram_read_data into the FIFO.
- Store with all byte enables set: drive bram_write_enable=1, bram_write_address=req_addr, bram_write_data=req_wdata in the same cycle. No response is returned.
- Store with all byte enables clear: accepted; the BRAM is not touched.
- Partial store:
  - Issue a BRAM read of req_addr.
  - Latch addr, byte_en and wdata.
  - Go to RMW_WRITE.
- RMW_WRITE:
  - req_ready=0.
  - Merge per byte: byte i = byte_en[i] ? wdata byte i : bram_read_data byte i.
  - Write the merged word to the latched address.
  - Return to ACCEPT.
  - No FIFO push. The inflight tag distinguishes RMW reads from loads.
- Ordering: responses are returned strictly in load-accept order. Stores are posted.
- Hazards:
  - Store then load to the same address on the next cycle: the load sees the new data, because the write commits at the edge.
  - RMW blocks new requests, so no request can overlap its write.
- Simultaneous FIFO push and pop: allowed at any occupancy, count unchanged.
- BRAM enables are 0 whenever no request is being accepted and the state is not RMW_WRITE.

## Timing
- Reset (asynchronous assert):
  - State = ACCEPT.
  - FIFO empty, inflight cleared.
  - req_ready=0, rsp_valid=0, rsp_rdata=0.
  - All bram_* outputs = 0.
  - A pending RMW write is dropped.
- req_ready goes to 1 in the first cycle after reset deasserts.
- Load latency: accept at cycle T → rsp_valid at T+2 (BRAM read T, push at end of T+1).
- Partial store: accept at T, write at T+1; req_ready=0 for exactly cycle T+1.
- Full store: write in the accept cycle, zero stall.
- rsp_valid/rsp_rdata hold stable while rsp_valid=1 and rsp_ready=0.

## Structure
- Package bram_ctrl_pkg holds:
  - the state encoding (ACCEPT, RMW_WRITE);
  - the byte-lane count constant (DATA_WIDTH/8);
  - the byte-merge function.
- Sub-module rsp_fifo: synchronous FIFO of RSP_DEPTH×DATA_WIDTH with async active-low reset, push/pop, and count output. It is instantiated once for the response path.

## Test plan
- Reset: with reset low, req_ready=0, rsp_valid=0 and all bram_* = 0. After release, req_ready=1 on the next cycle.
- Full store of 0xDEADBEEF to addr 5, then load addr 5 → rsp_rdata=0xDEADBEEF two cycles after the load is accepted.
- Partial store of 0x00001234 with byte_en=4'b0011 over 0xDEADBEEF at addr 5 → one-cycle req_ready drop, then a load returns 0xDEAD1234. Store with byte_en=0 → memory unchanged.
- Eight back-to-back loads to addrs 0–7 with rsp_ready=1 → one accept per cycle and eight in-order responses at T+2..T+9.
- rsp_ready=0 during a load burst:
  - req_ready falls after 4 loads are outstanding.
  - Data is held stable.
  - Raising rsp_ready drains all 4 in order with no loss or duplicates.
- Reset asserted during RMW_WRITE → no bram_write_enable pulse, target word unchanged, FIFO empty after release.

Source files
------------

// File: rtl/bram_ctrl_pkg.sv
// Shared definitions for the BRAM access controller: FSM encoding, lane math, byte merge.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package bram_ctrl_pkg;

  // FSM encoding kept as plain constants so older tools that dislike enums still parse it.
  localparam logic [0:0] ACCEPT    = 1'b0;
  localparam logic [0:0] RMW_WRITE = 1'b1;

  localparam int BYTE_BITS        = 8;
  localparam int DefaultDataWidth = 32;

  // Number of byte lanes in a word of the given width.
  function automatic int byteLanes(input int dataWidth);
    return dataWidth / BYTE_BITS;
  endfunction

  // One lane of the read-modify-write merge: enabled lanes take store data, others keep memory.
  function automatic logic [BYTE_BITS-1:0] mergeByte(
    input logic [BYTE_BITS-1:0] oldByte,
    input logic [BYTE_BITS-1:0] newByte,
    input logic                 enable
  );
    return enable ? newByte : oldByte;
  endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Response FIFO: DEPTH x WIDTH synchronous queue with occupancy count, head shown combinationally.
// Latency: a push is visible at the head on the cycle after the push edge.
// Backpressure: push is dropped only when full without a same-cycle pop; pop on empty is ignored.
module rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         headData,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PtrWidth   = $clog2(DEPTH);
  localparam int CountWidth = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PtrWidth-1:0] wrPtr;
  logic [PtrWidth-1:0] rdPtr;
  logic                doPush;
  logic                doPop;

  assign doPop    = pop && (count != '0);
  assign doPush   = push && ((count < CountWidth'(DEPTH)) || doPop);
  assign headData = mem[rdPtr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  // Pointers and occupancy; simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PtrWidth'(1);
      if (doPop)  rdPtr <= rdPtr + PtrWidth'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CountWidth'(1);
        2'b01:   count <= count - CountWidth'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bram_access_controller.sv
// Load/store front end for a registered-output BRAM; sub-word stores via read-modify-write.
// Latency: load accept T -> rsp_valid T+2; full store writes at T; partial store writes at T+1.
// Backpressure: req_ready credits outstanding loads against FIFO depth, independent of rsp_ready.
module bram_access_controller
  import bram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DefaultDataWidth,
  parameter int ADDR_WIDTH = 8,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH/8-1:0] req_byte_en,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    bram_read_enable,
  output logic [ADDR_WIDTH-1:0]   bram_read_address,
  input  logic [DATA_WIDTH-1:0]   bram_read_data,
  output logic                    bram_write_enable,
  output logic [ADDR_WIDTH-1:0]   bram_write_address,
  output logic [DATA_WIDTH-1:0]   bram_write_data
);

  localparam int Lanes      = byteLanes(DATA_WIDTH);
  localparam int CountWidth = $clog2(RSP_DEPTH) + 1;

  logic [0:0]            state;
  logic                  readyEn;
  logic                  inflightLoad;
  logic [ADDR_WIDTH-1:0] rmwAddr;
  logic [Lanes-1:0]      rmwByteEn;
  logic [DATA_WIDTH-1:0] rmwWdata;
  logic [DATA_WIDTH-1:0] mergedWord;
  logic [DATA_WIDTH-1:0] fifoHead;
  logic [CountWidth-1:0] fifoCount;
  logic [CountWidth:0]   pendingLoads;
  logic                  accept;
  logic                  acceptLoad;
  logic                  acceptFull;
  logic                  acceptPartial;
  logic                  inRmw;

  // Credit check: loads already in the FIFO plus the one whose BRAM data lands next cycle.
  assign pendingLoads = {1'b0, fifoCount} + {{CountWidth{1'b0}}, inflightLoad};
  assign inRmw        = (state == RMW_WRITE);
  assign req_ready    = readyEn && !inRmw && (pendingLoads < (CountWidth + 1)'(RSP_DEPTH));

  assign accept        = req_valid && req_ready;
  assign acceptLoad    = accept && !req_write;
  assign acceptFull    = accept && req_write && (&req_byte_en);
  assign acceptPartial = accept && req_write && (|req_byte_en) && !(&req_byte_en);

  // Byte merge of the latched store over the word read back during the RMW cycle.
  always_comb begin
    mergedWord = '0;
    for (int i = 0; i < Lanes; i++) begin
      mergedWord[i*BYTE_BITS +: BYTE_BITS] = mergeByte(bram_read_data[i*BYTE_BITS +: BYTE_BITS],
                                                       rmwWdata[i*BYTE_BITS +: BYTE_BITS],
                                                       rmwByteEn[i]);
    end
  end

  // BRAM port drive: reads for loads and RMW fetches, writes for full stores and RMW commits.
  always_comb begin
    bram_read_enable   = acceptLoad || acceptPartial;
    bram_read_address  = bram_read_enable ? req_addr : '0;
    bram_write_enable  = acceptFull || inRmw;
    bram_write_address = '0;
    bram_write_data    = '0;
    if (inRmw) begin
      bram_write_address = rmwAddr;
      bram_write_data    = mergedWord;
    end else if (acceptFull) begin
      bram_write_address = req_addr;
      bram_write_data    = req_wdata;
    end
  end

  // Control state: post-reset ready gating, FSM, load tag and RMW operand latch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      readyEn      <= 1'b0;
      state        <= ACCEPT;
      inflightLoad <= 1'b0;
      rmwAddr      <= '0;
      rmwByteEn    <= '0;
      rmwWdata     <= '0;
    end else begin
      readyEn      <= 1'b1;
      inflightLoad <= acceptLoad;
      case (state)
        ACCEPT: begin
          if (acceptPartial) begin
            state     <= RMW_WRITE;
            rmwAddr   <= req_addr;
            rmwByteEn <= req_byte_en;
            rmwWdata  <= req_wdata;
          end
        end
        default: state <= ACCEPT;
      endcase
    end
  end

  rsp_fifo #(
    .DEPTH(RSP_DEPTH),
    .WIDTH(DATA_WIDTH)
  ) u_rsp_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (inflightLoad),
    .pushData (bram_read_data),
    .pop      (rsp_valid && rsp_ready),
    .headData (fifoHead),
    .count    (fifoCount)
  );

  assign rsp_valid = (fifoCount != '0);
  assign rsp_rdata = rsp_valid ? fifoHead : '0;

endmodule
